// File: rtl/apb_master.sv
// APB master: turns a valid/ready command into one APB SETUP/ACCESS transfer and
// reports completion, slave error or wait-state timeout on a one-cycle response pulse.
module apb_master #(
    parameter int ADDRWIDTH = 3,
    parameter int DATAWIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic                 pwrite,
    output logic                 psel,
    output logic                 penable,
    output logic [DATAWIDTH-1:0] pwdata,
    input  logic [DATAWIDTH-1:0] prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Last ACCESS cycle before the wait-state abort fires.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                 state_reg, state_next;
    logic [7:0]             wait_cnt_reg, wait_cnt_next;
    logic [ADDRWIDTH-1:0]   paddr_reg, paddr_next;
    logic                   pwrite_reg, pwrite_next;
    logic [DATAWIDTH-1:0]   pwdata_reg, pwdata_next;
    logic                   psel_reg, psel_next;
    logic                   penable_reg, penable_next;
    logic                   rsp_valid_reg, rsp_valid_next;
    logic [DATAWIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                   rsp_err_reg, rsp_err_next;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            paddr_reg     <= '0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            paddr_reg     <= paddr_next;
            pwrite_reg    <= pwrite_next;
            pwdata_reg    <= pwdata_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        paddr_next     = paddr_reg;
        pwrite_next    = pwrite_reg;
        pwdata_next    = pwdata_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;

        case (state_reg)
            IDLE: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                if (cmd_valid) begin
                    state_next    = SETUP;
                    wait_cnt_next = '0;
                    paddr_next    = cmd_addr;
                    pwrite_next   = cmd_write;
                    pwdata_next   = cmd_write ? cmd_wdata : '0;
                    psel_next     = 1'b1;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                psel_next    = 1'b1;
                penable_next = 1'b1;
            end
            ACCESS: begin
                // A ready slave wins over a timeout landing on the same edge.
                if (pready) begin
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = pslverr;
                    rsp_rdata_next = pwrite_reg ? '0 : prdata;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_reg == IDLE);
    assign paddr     = paddr_reg;
    assign pwrite    = pwrite_reg;
    assign pwdata    = pwdata_reg;
    assign psel      = psel_reg;
    assign penable   = penable_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    // Protocol sanity: an enabled phase always sits inside a selected transfer.
    assert property (@(posedge pclk) disable iff (preset) penable_reg |-> psel_reg);
    assert property (@(posedge pclk) disable iff (preset) rsp_valid_reg |-> (state_reg == IDLE));

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 3, meaning APB address width.
REQ-002 The block SHALL have parameter DATAWIDTH, default 8, meaning APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning maximum ACCESS cycles with pready low before abort (range 2..255).
REQ-004 The block SHALL have port pclk  input  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port preset  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port cmd_valid  input  1  command request.
REQ-007 The block SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 The block SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 The block SHALL have port cmd_addr  input  ADDRWIDTH  target address.
REQ-010 The block SHALL have port cmd_wdata  input  DATAWIDTH  write data.
REQ-011 The block SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata  output  DATAWIDTH  read data, valid with rsp_valid.
REQ-013 The block SHALL have port rsp_err  output  1  error flag, valid with rsp_valid.
REQ-014 The block SHALL have ports paddr (ADDRWIDTH), pwrite (1), psel (1), penable (1), pwdata (DATAWIDTH) as outputs, and prdata (DATAWIDTH), pready (1), pslverr (1) as inputs, with standard APB meaning.

Function
REQ-015 The block SHALL implement states IDLE, SETUP, ACCESS; all APB and rsp outputs registered.
REQ-016 cmd_ready SHALL be high exactly when state is IDLE.
REQ-017 In IDLE, a rising edge with cmd_valid high SHALL latch cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata and move to SETUP; cmd_valid low keeps IDLE.
REQ-018 pwdata SHALL load cmd_wdata for writes and all-zeros for reads.
REQ-019 In SETUP, psel=1 and penable=0 for exactly one cycle; next state ACCESS unconditionally.
REQ-020 In ACCESS, psel=1 and penable=1; paddr, pwrite, pwdata SHALL remain stable until exit.
REQ-021 In ACCESS, a rising edge with pready=1 SHALL return to IDLE, deassert psel/penable, pulse rsp_valid for one cycle, set rsp_err=pslverr, set rsp_rdata=prdata for reads and zero for writes.
REQ-022 A wait counter SHALL clear on SETUP entry and increment on each ACCESS edge with pready=0.
REQ-023 When the counter reaches TIMEOUT-1 with pready still low, the next edge SHALL abort: return to IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-024 pready=1 on the same edge the timeout would fire SHALL complete normally (REQ-021 wins).
REQ-025 Latency: cmd accept edge to rsp_valid high SHALL be 2 cycles with zero wait states; N wait states add N cycles.
REQ-026 A new command SHALL be accepted no earlier than the cycle in which rsp_valid is high (back-to-back: one IDLE cycle between transfers).
REQ-027 In IDLE, paddr/pwrite/pwdata SHALL hold last values; psel=penable=0; rsp_rdata/rsp_err hold until next completion.
REQ-028 prdata, pready, pslverr SHALL be ignored outside ACCESS.

Reset
REQ-029 While preset=1, state SHALL be IDLE, wait counter 0, and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0, independent of pclk.
REQ-030 Reset asserted during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid pulse; after release cmd_ready=1 on the first cycle.

Verification
REQ-031 Write, zero wait: cmd addr=3'h5, wdata=8'hA5, pready=1 -> SETUP cycle with paddr=5/pwrite=1/pwdata=A5, ACCESS one cycle, rsp_valid two cycles after accept, rsp_err=0.
REQ-032 Read, 3 wait states: addr=3'h2, prdata=8'h3C with pready high on 4th ACCESS cycle -> rsp_rdata=3C, rsp_err=0, latency 5 cycles.
REQ-033 Slave error: read with pready=1, pslverr=1 -> rsp_valid with rsp_err=1.
REQ-034 Timeout: pready held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_valid, rsp_err=1, rsp_rdata=0; pready=1 on 16th cycle -> normal completion.
REQ-035 Back-to-back: cmd_valid held high for two writes -> one IDLE cycle between transfers, two rsp_valid pulses, APB protocol never shows penable without prior SETUP.
REQ-036 Reset in ACCESS: assert preset mid-wait -> psel/penable drop immediately, no rsp_valid, cmd_ready=1 after release.
